// File: rtl/branch_checkpoint_stack.sv
// rtl/branch_checkpoint_stack.sv - per-branch recovery checkpoint stack (optional BRANCH_STACK_PERF_EN counters)
`ifndef PHYS_REG_SZ_R10K
`define PHYS_REG_SZ_R10K 64
`endif
`ifndef ARCH_REG_SZ_R10K
`define ARCH_REG_SZ_R10K 32
`endif
`ifndef PHYS_REG_ID_BITS
`define PHYS_REG_ID_BITS 6
`endif
`ifndef N
`define N 3
`endif
`ifndef NUM_SCALAR_BITS
`define NUM_SCALAR_BITS 2
`endif

module branch_checkpoint_stack #(
  parameter int NUM_CHECKPOINTS = 4,
  parameter int ROB_IDX_BITS    = 5
) (
  input  logic                                                    clock,
  input  logic                                                    reset,
  input  logic                                                    branch_dispatch_valid,
  input  logic [`PHYS_REG_SZ_R10K-1:0]                            dispatch_free_list,
  input  logic [`ARCH_REG_SZ_R10K-1:0][`PHYS_REG_ID_BITS-1:0]     dispatch_map_table,
  input  logic [ROB_IDX_BITS-1:0]                                 dispatch_rob_tail,
  output logic                                                    stack_full,
  output logic [NUM_CHECKPOINTS-1:0]                              assigned_tag,
  output logic [NUM_CHECKPOINTS-1:0]                              current_branch_mask,
  input  logic [`N-1:0][`PHYS_REG_ID_BITS-1:0]                    phys_regs_retiring,
  input  logic [`NUM_SCALAR_BITS-1:0]                             num_retiring_valid,
  input  logic                                                    resolve_valid,
  input  logic [NUM_CHECKPOINTS-1:0]                              resolve_tag,
  input  logic                                                    resolve_mispredict,
  output logic                                                    restore_flag,
  output logic [`PHYS_REG_SZ_R10K-1:0]                            free_list_restore,
  output logic [`ARCH_REG_SZ_R10K-1:0][`PHYS_REG_ID_BITS-1:0]     map_table_restore,
  output logic [ROB_IDX_BITS-1:0]                                 rob_tail_restore,
  output logic [NUM_CHECKPOINTS-1:0]                              squash_mask,
  output logic [NUM_CHECKPOINTS-1:0]                              resolved_tag
`ifdef BRANCH_STACK_PERF_EN
  ,
  output logic [31:0]                                             perf_resolved_cnt,
  output logic [31:0]                                             perf_mispredict_cnt
`endif
);

  localparam int PR = `PHYS_REG_SZ_R10K;
  localparam int AR = `ARCH_REG_SZ_R10K;
  localparam int PB = `PHYS_REG_ID_BITS;

  typedef logic [AR-1:0][PB-1:0] map_t;

  logic [NUM_CHECKPOINTS-1:0] valid;
  logic [NUM_CHECKPOINTS-1:0] valid_next;
  logic [NUM_CHECKPOINTS-1:0] dep_mask  [NUM_CHECKPOINTS];
  logic [PR-1:0]              free_snap [NUM_CHECKPOINTS];
  map_t                       map_snap  [NUM_CHECKPOINTS];
  logic [ROB_IDX_BITS-1:0]    rob_snap  [NUM_CHECKPOINTS];

  logic [PR-1:0]              retire_mask;
  logic [NUM_CHECKPOINTS-1:0] alloc_onehot;
  logic [NUM_CHECKPOINTS-1:0] squash_raw;
  logic [PR-1:0]              sel_free;
  map_t                       sel_map;
  logic [ROB_IDX_BITS-1:0]    sel_rob;
  logic                       mispredict;
  logic                       correct;
  logic                       do_alloc;

  assign mispredict = resolve_valid && resolve_mispredict;
  assign correct    = resolve_valid && !resolve_mispredict;
  assign do_alloc   = branch_dispatch_valid && !stack_full && !mispredict;

  // Registers released by retirement this cycle, folded into live free snapshots.
  always_comb begin
    retire_mask = '0;
    for (int i = 0; i < `N; i++) begin
      if (i < int'(num_retiring_valid)) begin
        retire_mask[phys_regs_retiring[i]] = 1'b1;
      end
    end
  end

  // Lowest-index free slot as a one-hot (scan from the top so the lowest wins).
  always_comb begin
    alloc_onehot = '0;
    for (int s = NUM_CHECKPOINTS - 1; s >= 0; s--) begin
      if (!valid[s]) begin
        alloc_onehot    = '0;
        alloc_onehot[s] = 1'b1;
      end
    end
  end

  // Mispredicted slot plus every live slot allocated while it was live.
  always_comb begin
    squash_raw = resolve_tag;
    for (int s = 0; s < NUM_CHECKPOINTS; s++) begin
      if (valid[s] && |(dep_mask[s] & resolve_tag)) begin
        squash_raw[s] = 1'b1;
      end
    end
  end

  // One-hot select of the resolving slot's snapshots.
  always_comb begin
    sel_free = '0;
    sel_map  = '0;
    sel_rob  = '0;
    for (int s = 0; s < NUM_CHECKPOINTS; s++) begin
      if (resolve_tag[s]) begin
        sel_free = sel_free | free_snap[s];
        sel_map  = sel_map  | map_snap[s];
        sel_rob  = sel_rob  | rob_snap[s];
      end
    end
  end

  // Live-slot vector after this cycle's resolve, squash and allocation.
  always_comb begin
    valid_next = valid;
    if (correct) begin
      valid_next = valid_next & ~resolve_tag;
    end
    if (mispredict) begin
      valid_next = valid_next & ~squash_raw;
    end
    if (do_alloc) begin
      valid_next = valid_next | alloc_onehot;
    end
  end

  // Combinational outputs, held at zero when not active or while in reset.
  always_comb begin
    assigned_tag      = '0;
    restore_flag      = 1'b0;
    free_list_restore = '0;
    map_table_restore = '0;
    rob_tail_restore  = '0;
    squash_mask       = '0;
    resolved_tag      = '0;
    if (!reset) begin
      if (do_alloc) begin
        assigned_tag = alloc_onehot;
      end
      if (mispredict) begin
        restore_flag      = 1'b1;
        free_list_restore = sel_free;
        map_table_restore = sel_map;
        rob_tail_restore  = sel_rob;
        squash_mask       = squash_raw;
      end
      if (correct) begin
        resolved_tag = resolve_tag;
      end
    end
  end

  assign current_branch_mask = valid;

  // Slot state: validity, dependency masks, snapshots and retire merging.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid      <= '0;
      stack_full <= 1'b0;
      for (int s = 0; s < NUM_CHECKPOINTS; s++) begin
        dep_mask[s]  <= '0;
        free_snap[s] <= '0;
        map_snap[s]  <= '0;
        rob_snap[s]  <= '0;
      end
    end else begin
      valid      <= valid_next;
      stack_full <= &valid_next;
      for (int s = 0; s < NUM_CHECKPOINTS; s++) begin
        if (valid[s]) begin
          free_snap[s] <= free_snap[s] | retire_mask;
        end
        if (correct) begin
          dep_mask[s] <= dep_mask[s] & ~resolve_tag;
        end
        if (do_alloc && alloc_onehot[s]) begin
          free_snap[s] <= dispatch_free_list | retire_mask;
          map_snap[s]  <= dispatch_map_table;
          rob_snap[s]  <= dispatch_rob_tail;
          dep_mask[s]  <= valid & ~(resolve_valid ? resolve_tag : '0);
        end
      end
    end
  end

`ifdef BRANCH_STACK_PERF_EN
  // Free-running resolve and mispredict event counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_resolved_cnt   <= '0;
      perf_mispredict_cnt <= '0;
    end else begin
      if (resolve_valid) begin
        perf_resolved_cnt <= perf_resolved_cnt + 32'd1;
      end
      if (mispredict) begin
        perf_mispredict_cnt <= perf_mispredict_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_checkpoint_stack.sv
// tb/tb_branch_checkpoint_stack.sv - self-checking bench for branch_checkpoint_stack
`ifndef PHYS_REG_SZ_R10K
`define PHYS_REG_SZ_R10K 64
`endif
`ifndef ARCH_REG_SZ_R10K
`define ARCH_REG_SZ_R10K 32
`endif
`ifndef PHYS_REG_ID_BITS
`define PHYS_REG_ID_BITS 6
`endif
`ifndef N
`define N 3
`endif
`ifndef NUM_SCALAR_BITS
`define NUM_SCALAR_BITS 2
`endif

module tb_branch_checkpoint_stack;

  localparam int NC = 4;
  localparam int RB = 5;
  localparam int PR = `PHYS_REG_SZ_R10K;
  localparam int AR = `ARCH_REG_SZ_R10K;
  localparam int PB = `PHYS_REG_ID_BITS;

  typedef logic [AR-1:0][PB-1:0] map_t;

  logic                         clock;
  logic                         reset;
  logic                         bd;
  logic [PR-1:0]                dfl;
  map_t                         dmt;
  logic [RB-1:0]                drt;
  logic                         stack_full;
  logic [NC-1:0]                assigned_tag;
  logic [NC-1:0]                current_branch_mask;
  logic [`N-1:0][PB-1:0]        prr;
  logic [`NUM_SCALAR_BITS-1:0]  nrv;
  logic                         rv;
  logic [NC-1:0]                rtag;
  logic                         rmis;
  logic                         restore_flag;
  logic [PR-1:0]                free_list_restore;
  map_t                         map_table_restore;
  logic [RB-1:0]                rob_tail_restore;
  logic [NC-1:0]                squash_mask;
  logic [NC-1:0]                resolved_tag;
`ifdef BRANCH_STACK_PERF_EN
  logic [31:0]                  perf_resolved_cnt;
  logic [31:0]                  perf_mispredict_cnt;
`endif

  branch_checkpoint_stack #(.NUM_CHECKPOINTS(NC), .ROB_IDX_BITS(RB)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .branch_dispatch_valid (bd),
    .dispatch_free_list    (dfl),
    .dispatch_map_table    (dmt),
    .dispatch_rob_tail     (drt),
    .stack_full            (stack_full),
    .assigned_tag          (assigned_tag),
    .current_branch_mask   (current_branch_mask),
    .phys_regs_retiring    (prr),
    .num_retiring_valid    (nrv),
    .resolve_valid         (rv),
    .resolve_tag           (rtag),
    .resolve_mispredict    (rmis),
    .restore_flag          (restore_flag),
    .free_list_restore     (free_list_restore),
    .map_table_restore     (map_table_restore),
    .rob_tail_restore      (rob_tail_restore),
    .squash_mask           (squash_mask),
    .resolved_tag          (resolved_tag)
`ifdef BRANCH_STACK_PERF_EN
    ,
    .perf_resolved_cnt     (perf_resolved_cnt),
    .perf_mispredict_cnt   (perf_mispredict_cnt)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int errors = 0;
  int checks = 0;

  // Reference model: live checkpoints kept oldest-first, snapshots per slot.
  int            q[$];
  logic [PR-1:0] m_free [NC];
  map_t          m_map  [NC];
  logic [RB-1:0] m_rob  [NC];
  int unsigned   m_res_cnt;
  int unsigned   m_mis_cnt;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_q(input int s);
    foreach (q[k]) if (q[k] == s) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int pos_in_q(input int s);
    foreach (q[k]) if (q[k] == s) return k;
    return -1;
  endfunction

  function automatic logic [NC-1:0] q_bits();
    logic [NC-1:0] b;
    b = '0;
    foreach (q[k]) b[q[k]] = 1'b1;
    return b;
  endfunction

  function automatic int lowest_free();
    for (int s = 0; s < NC; s++) if (!in_q(s)) return s;
    return -1;
  endfunction

  function automatic int tag_slot(input logic [NC-1:0] t);
    for (int s = 0; s < NC; s++) if (t[s]) return s;
    return -1;
  endfunction

  function automatic logic [PR-1:0] retire_bits();
    logic [PR-1:0] m;
    m = '0;
    for (int i = 0; i < int'(nrv); i++) m[prr[i]] = 1'b1;
    return m;
  endfunction

  task automatic idle();
    bd = 1'b0; dfl = '0; dmt = '0; drt = '0;
    prr = '0; nrv = '0; rv = 1'b0; rtag = '0; rmis = 1'b0;
  endtask

  task automatic rand_dispatch();
    bd  = 1'b1;
    dfl = {$urandom, $urandom};
    for (int a = 0; a < AR; a++) dmt[a] = PB'($urandom);
    drt = RB'($urandom);
  endtask

  task automatic resolve(input int s, input bit mis);
    rv = 1'b1; rtag = '0; rtag[s] = 1'b1; rmis = mis;
  endtask

  // Let inputs settle and compare every output against the model.
  task automatic settle();
    logic [NC-1:0] e_assigned, e_squash, e_resolved;
    logic [PR-1:0] e_free;
    map_t          e_map;
    logic [RB-1:0] e_rob;
    int            t, p, fs;
    bit            mp, cr;
    #1;
    e_assigned = '0; e_squash = '0; e_resolved = '0;
    e_free = '0; e_map = '0; e_rob = '0;
    if (reset) begin
      chk("rst_assigned", assigned_tag, e_assigned);
      chk("rst_restore_flag", restore_flag, 1'b0);
      chk("rst_squash", squash_mask, e_squash);
      chk("rst_resolved", resolved_tag, e_resolved);
    end else begin
      mp = rv && rmis;
      cr = rv && !rmis;
      t  = tag_slot(rtag);
      if (rv) chk("legal_resolve_tag", {$onehot(rtag), in_q(t)}, 2'b11);
      fs = lowest_free();
      if (bd && q.size() < NC && !mp) e_assigned[fs] = 1'b1;
      if (mp && t >= 0) begin
        p = pos_in_q(t);
        e_squash = rtag;
        if (p >= 0) for (int k = p; k < q.size(); k++) e_squash[q[k]] = 1'b1;
        e_free = m_free[t]; e_map = m_map[t]; e_rob = m_rob[t];
      end
      if (cr) e_resolved = rtag;
      chk("assigned_tag", assigned_tag, e_assigned);
      chk("stack_full", stack_full, q.size() == NC);
      chk("branch_mask", current_branch_mask, q_bits());
      chk("restore_flag", restore_flag, mp);
      chk("free_list_restore", free_list_restore, e_free);
      chk("map_table_restore", map_table_restore, e_map);
      chk("rob_tail_restore", rob_tail_restore, e_rob);
      chk("squash_mask", squash_mask, e_squash);
      chk("resolved_tag", resolved_tag, e_resolved);
    end
  endtask

  // Clock edge: apply the same inputs to the model.
  task automatic advance();
    logic [PR-1:0] rm;
    int  t, p, fs;
    bit  mp, cr, al;
    @(posedge clock);
    if (reset) begin
      q.delete();
      m_res_cnt = 0;
      m_mis_cnt = 0;
    end else begin
      rm = retire_bits();
      mp = rv && rmis;
      cr = rv && !rmis;
      t  = tag_slot(rtag);
      fs = lowest_free();
      al = bd && q.size() < NC && !mp;
      if (rv) m_res_cnt++;
      if (mp) m_mis_cnt++;
      foreach (q[k]) m_free[q[k]] = m_free[q[k]] | rm;
      if (cr) begin
        p = pos_in_q(t);
        if (p >= 0) q.delete(p);
      end
      if (mp) begin
        p = pos_in_q(t);
        if (p >= 0) while (q.size() > p) void'(q.pop_back());
      end
      if (al) begin
        q.push_back(fs);
        m_free[fs] = dfl | rm;
        m_map[fs]  = dmt;
        m_rob[fs]  = drt;
      end
    end
    @(negedge clock);
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  task automatic do_reset();
    idle(); reset = 1'b1; step(); step(); reset = 1'b0;
  endtask

  initial begin
    m_res_cnt = 0;
    m_mis_cnt = 0;
    idle();
    reset = 1'b1;
    @(negedge clock);
    do_reset();

    // Reset state.
    idle(); settle();
    chk("reset_mask", current_branch_mask, 4'b0000);
    chk("reset_full", stack_full, 1'b0);
    advance();

    // Four consecutive dispatches, then a fifth against a full stack.
    for (int k = 0; k < NC; k++) begin
      logic [NC-1:0] tg;
      idle(); rand_dispatch(); settle();
      tg = '0; tg[k] = 1'b1;
      chk("dispatch_tag", assigned_tag, tg);
      advance();
    end
    idle(); settle(); chk("full_after_4", stack_full, 1'b1); advance();
    idle(); rand_dispatch(); settle(); chk("fifth_tag", assigned_tag, 4'b0000); advance();
    idle(); settle(); chk("fifth_no_change", current_branch_mask, 4'b1111); advance();

    // Correct resolve of 0010 with four live.
    idle(); resolve(1, 1'b0); settle(); chk("resolved_0010", resolved_tag, 4'b0010); advance();
    idle(); rand_dispatch(); settle();
    chk("after_resolve_mask", current_branch_mask, 4'b1101);
    chk("after_resolve_full", stack_full, 1'b0);
    chk("reuse_tag", assigned_tag, 4'b0010);
    advance();

    // Mispredict of 0010 with slots 0..3 allocated in order.
    do_reset();
    for (int k = 0; k < NC; k++) begin
      idle(); rand_dispatch(); drt = RB'(10 + k); step();
    end
    idle(); resolve(1, 1'b1); settle();
    chk("mp_flag", restore_flag, 1'b1);
    chk("mp_squash", squash_mask, 4'b1110);
    chk("mp_rob_tail", rob_tail_restore, 5'd11);
    advance();
    idle(); settle(); chk("mp_after_mask", current_branch_mask, 4'b0001); advance();

    // Retire merge into a live snapshot, then mispredict with a same-cycle dispatch.
    idle(); rand_dispatch(); dfl[40] = 1'b0; step();
    idle(); nrv = 2'd1; prr[0] = PB'(40); step();
    idle(); rand_dispatch(); resolve(1, 1'b1); settle();
    chk("merge_bit40", free_list_restore[40], 1'b1);
    chk("drop_dispatch_tag", assigned_tag, 4'b0000);
    chk("merge_squash", squash_mask, 4'b0010);
    advance();
    idle(); settle(); chk("drop_dispatch_mask", current_branch_mask, 4'b0001); advance();

    // Same-cycle dispatch and correct resolve: new dep_mask excludes the resolved tag.
    idle(); rand_dispatch(); resolve(0, 1'b0); settle();
    chk("dr_assigned", assigned_tag, 4'b0010);
    chk("dr_resolved", resolved_tag, 4'b0001);
    advance();
    idle(); rand_dispatch(); settle(); chk("dr_realloc", assigned_tag, 4'b0001); advance();
    idle(); resolve(0, 1'b1); settle(); chk("dr_squash_excl", squash_mask, 4'b0001); advance();
    idle(); settle(); chk("dr_mask", current_branch_mask, 4'b0010); advance();

    // Reset during a mispredict cycle.
    idle(); rand_dispatch(); step();
    idle(); rand_dispatch(); resolve(1, 1'b1); reset = 1'b1; step(); reset = 1'b0;
    idle(); settle();
    chk("rmp_mask", current_branch_mask, 4'b0000);
    chk("rmp_full", stack_full, 1'b0);
    chk("rmp_flag", restore_flag, 1'b0);
    chk("rmp_squash", squash_mask, 4'b0000);
    chk("rmp_rob", rob_tail_restore, 5'd0);
    chk("rmp_free", free_list_restore, '0);
    advance();

    // Three resolves, one of them a mispredict.
    for (int k = 0; k < 3; k++) begin
      idle(); rand_dispatch(); step();
    end
    idle(); resolve(0, 1'b0); step();
    idle(); resolve(1, 1'b0); step();
    idle(); resolve(2, 1'b1); step();
`ifdef BRANCH_STACK_PERF_EN
    idle(); settle();
    chk("perf_resolved_3", perf_resolved_cnt, 32'd3);
    chk("perf_mispredict_1", perf_mispredict_cnt, 32'd1);
    advance();
`endif

    // Randomized traffic against the model.
    for (int c = 0; c < 500; c++) begin
      idle();
      if ($urandom_range(0, 1) == 1) rand_dispatch();
      nrv = `NUM_SCALAR_BITS'($urandom_range(0, `N));
      for (int i = 0; i < `N; i++) prr[i] = PB'($urandom);
      if (q.size() > 0 && $urandom_range(0, 9) < 4) begin
        resolve(q[$urandom_range(0, q.size() - 1)], $urandom_range(0, 9) < 3);
      end
      reset = ($urandom_range(0, 99) == 0);
      step();
      reset = 1'b0;
    end

    idle(); settle();
`ifdef BRANCH_STACK_PERF_EN
    chk("perf_resolved_end", perf_resolved_cnt, 32'(m_res_cnt));
    chk("perf_mispredict_end", perf_mispredict_cnt, 32'(m_mis_cnt));
`endif
    advance();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_checkpoint_stack.md
Name: branch_checkpoint_stack

Overview:
- Holds per-branch recovery checkpoints for the R10K pipeline. Each checkpoint contains a free-list snapshot, a map-table snapshot and a ROB tail.
- Allocates one checkpoint per dispatched branch and tags it one-hot.
- Frees the checkpoint on a correct resolve. On a mispredict, drives the restore image to the free list, map table and ROB, and squashes all younger checkpoints.
- Sits between dispatch/execute and the free list. It is the source of the free list's `free_list_restore` and `restore_flag` inputs.

Parameters:
- NUM_CHECKPOINTS, 4, number of checkpoint slots (one-hot tag width).
- ROB_IDX_BITS, 5, width of the ROB tail index.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- branch_dispatch_valid  in  1  a branch dispatches this cycle
- dispatch_free_list  in  `PHYS_REG_SZ_R10K  free list after this cycle's dispatch allocations
- dispatch_map_table  in  `ARCH_REG_SZ_R10K x `PHYS_REG_ID_BITS  map table after this cycle's dispatch renames
- dispatch_rob_tail  in  ROB_IDX_BITS  ROB tail immediately after the branch
- stack_full  out  1  no free slot (registered state only)
- assigned_tag  out  NUM_CHECKPOINTS  one-hot tag for the dispatching branch; 0 if none
- current_branch_mask  out  NUM_CHECKPOINTS  valid-checkpoint vector; dispatch attaches it to each instruction
- phys_regs_retiring  in  `N x `PHYS_REG_ID_BITS  T_old of retiring instructions
- num_retiring_valid  in  `NUM_SCALAR_BITS  count of valid entries, lowest-first
- resolve_valid  in  1  a branch resolves this cycle
- resolve_tag  in  NUM_CHECKPOINTS  one-hot tag of the resolving branch
- resolve_mispredict  in  1  the resolving branch mispredicted
- restore_flag  out  1  mispredict restore is active this cycle
- free_list_restore  out  `PHYS_REG_SZ_R10K  free-list snapshot of the mispredicted checkpoint
- map_table_restore  out  `ARCH_REG_SZ_R10K x `PHYS_REG_ID_BITS  map-table snapshot
- rob_tail_restore  out  ROB_IDX_BITS  ROB tail snapshot
- squash_mask  out  NUM_CHECKPOINTS  mispredicted tag plus all younger tags
- resolved_tag  out  NUM_CHECKPOINTS  tag to clear from instruction masks on a correct resolve

Behaviour:
- **Per-slot state:** valid, dep_mask (older live tags at allocation), free snapshot, map snapshot, rob_tail.
- **Reset:**
  - All slots invalid; all snapshots and dep_masks are 0.
  - All outputs are 0.
  - Reset overrides all simultaneous inputs, including mid-restore.
- **Allocation:**
  - Allocate when branch_dispatch_valid && !stack_full && !(resolve_valid && resolve_mispredict).
  - The slot is the lowest-index invalid slot; assigned_tag is its one-hot, combinational in the same cycle.
  - At the next edge: write the snapshots; free snapshot = dispatch_free_list | the retiring regs of this cycle; dep_mask = valid & ~(resolve_tag if resolve_valid).
- **stack_full:** = &valid (registered). A slot freed this cycle is reusable only next cycle.
- **Retire merge:** each cycle, for i < num_retiring_valid, set bit phys_regs_retiring[i] in the free snapshot of every valid slot. This prevents leaks of registers freed after the snapshot was taken.
- **Correct resolve** (resolve_valid && !resolve_mispredict):
  - resolved_tag = resolve_tag, combinational.
  - Next edge: clear that slot's valid bit and clear the tag bit in every dep_mask.
- **Mispredict** (resolve_valid && resolve_mispredict):
  - Same cycle, combinational: restore_flag = 1; free_list_restore, map_table_restore and rob_tail_restore come from the slot of resolve_tag.
  - free_list_restore includes any retire merges already applied.
  - squash_mask = resolve_tag | the tags of all valid slots whose dep_mask contains resolve_tag.
  - Next edge: invalidate every slot in squash_mask. Any dispatch that cycle is dropped.
- **Illegal input:** resolve_tag not matching a valid slot, or not one-hot. This is a bench assertion; the RTL result is don't-care.
- **Output hold:** restore outputs are 0 when restore_flag = 0, and resolved_tag is 0 otherwise.
- **Limit:** at most one dispatch and one resolve per cycle.

Optional Feature:
- BRANCH_STACK_PERF_EN adds two outputs: perf_resolved_cnt[31:0] and perf_mispredict_cnt[31:0].
  - perf_resolved_cnt increments on every resolve_valid; perf_mispredict_cnt increments on every mispredict.
  - Both reset to 0 and wrap at 2^32.
- Without the macro, neither the ports nor the counters exist.

Test Plan:
- **Reset then 4 dispatches:** dispatch on consecutive cycles → tags 0001, 0010, 0100, 1000; stack_full = 1 after the 4th edge; a 5th dispatch returns assigned_tag = 0 and no state change.
- **Correct resolve of 0010 with 4 valid:** resolved_tag = 0010; next cycle, valid = 1101, slot-3 dep_mask = 0101, stack_full = 0; a new dispatch gets 0010.
- **Mispredict of 0010 with slots 0–3 allocated in order:** restore_flag = 1, squash_mask = 1110, rob_tail_restore = slot-1 value; next cycle, valid = 0001.
- **Retire merge:** checkpoint with free snapshot bit 40 = 0; retire T_old = 40; later mispredict → free_list_restore[40] = 1.
- **Same-cycle dispatch + mispredict:** dispatch is dropped (valid unchanged beyond squash). Same-cycle dispatch + correct resolve: the new slot's dep_mask excludes the resolving tag.
- **Reset asserted during a mispredict cycle:** next cycle, all valid = 0 and all outputs = 0. With BRANCH_STACK_PERF_EN: 3 resolves including 1 mispredict → counters read 3 and 1.
